// File: rtl/aemb_wbarb.sv
// Two-port Wishbone arbiter: instruction and data masters share a single bus.
// Contention alternates between ports, and a stalled slave is released by a cycle timeout.
module aemb_wbarb #(
   parameter int         AW  = 32,
   parameter logic [7:0] TMO = 8'd255
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_i,
   // instruction port
   input  logic          iwb_stb_i,
   input  logic [AW-3:0] iwb_adr_i,
   output logic [31:0]   iwb_dat_o,
   output logic          iwb_ack_o,
   output logic          iwb_err_o,
   // data port
   input  logic          dwb_stb_i,
   input  logic          dwb_wre_i,
   input  logic [3:0]    dwb_sel_i,
   input  logic [AW-3:0] dwb_adr_i,
   input  logic [31:0]   dwb_dat_i,
   output logic [31:0]   dwb_dat_o,
   output logic          dwb_ack_o,
   output logic          dwb_err_o,
   // shared bus
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_wre_o,
   output logic [3:0]    wb_sel_o,
   output logic [AW-3:0] wb_adr_o,
   output logic [31:0]   wb_dat_o,
   input  logic [31:0]   wb_dat_i,
   input  logic          wb_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GNT_I = 2'b01,
      S_GNT_D = 2'b10
   } state_t;

   // lst: 1'b0 means the instruction port was served last, 1'b1 the data port
   state_t        state_q, state_d;
   logic          lst_q, lst_d;
   logic [8:0]    cnt_q, cnt_d;
   logic          stb_q, stb_d;
   logic          wre_q, wre_d;
   logic [3:0]    sel_q, sel_d;
   logic [AW-3:0] adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [31:0]   idat_q, idat_d;
   logic [31:0]   ddat_q, ddat_d;
   logic          iack_s, dack_s, ierr_s, derr_s;
   logic          gnt_d_s, gnt_i_s, tmo_hit_s;

   assign tmo_hit_s = (TMO != 8'd0) && (cnt_q == {1'b0, TMO});
   assign gnt_d_s   = dwb_stb_i & (~iwb_stb_i | ~lst_q);
   assign gnt_i_s   = iwb_stb_i & ~gnt_d_s;

   // state register and bus-field registers
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q <= S_IDLE;
         lst_q   <= 1'b0;
         cnt_q   <= 9'd0;
         stb_q   <= 1'b0;
         wre_q   <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= {(AW-2){1'b0}};
         dat_q   <= 32'h0000_0000;
         idat_q  <= 32'h0000_0000;
         ddat_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         lst_q   <= lst_d;
         cnt_q   <= cnt_d;
         stb_q   <= stb_d;
         wre_q   <= wre_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         idat_q  <= idat_d;
         ddat_q  <= ddat_d;
      end
   end

   // next-state, grant capture and completion decode
   always_comb begin
      state_d = state_q;
      lst_d   = lst_q;
      cnt_d   = cnt_q;
      stb_d   = stb_q;
      wre_d   = wre_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      idat_d  = idat_q;
      ddat_d  = ddat_q;
      iack_s  = 1'b0;
      dack_s  = 1'b0;
      ierr_s  = 1'b0;
      derr_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gnt_d_s) begin
               state_d = S_GNT_D;
               stb_d   = 1'b1;
               cnt_d   = 9'd0;
               adr_d   = dwb_adr_i;
               sel_d   = dwb_sel_i;
               wre_d   = dwb_wre_i;
               dat_d   = dwb_dat_i;
            end else if (gnt_i_s) begin
               state_d = S_GNT_I;
               stb_d   = 1'b1;
               cnt_d   = 9'd0;
               adr_d   = iwb_adr_i;
               sel_d   = 4'hF;
               wre_d   = 1'b0;
            end else begin
               stb_d   = 1'b0;
            end
         end
         S_GNT_I: begin
            if (wb_ack_i) begin
               iack_s  = 1'b1;
               idat_d  = wb_dat_i;
               lst_d   = 1'b0;
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else if (!iwb_stb_i) begin
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else if (tmo_hit_s) begin
               ierr_s  = 1'b1;
               lst_d   = 1'b0;
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else begin
               cnt_d   = cnt_q + 9'd1;
            end
         end
         S_GNT_D: begin
            if (wb_ack_i) begin
               dack_s  = 1'b1;
               ddat_d  = wb_dat_i;
               lst_d   = 1'b1;
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else if (!dwb_stb_i) begin
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else if (tmo_hit_s) begin
               derr_s  = 1'b1;
               lst_d   = 1'b1;
               state_d = S_IDLE;
               stb_d   = 1'b0;
            end else begin
               cnt_d   = cnt_q + 9'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            stb_d   = 1'b0;
         end
      endcase
   end

   // a reset edge must not complete the transaction it aborts
   assign iwb_ack_o = iack_s & ~sys_rst_i;
   assign dwb_ack_o = dack_s & ~sys_rst_i;
   assign iwb_err_o = ierr_s & ~sys_rst_i;
   assign dwb_err_o = derr_s & ~sys_rst_i;
   assign iwb_dat_o = iwb_ack_o ? wb_dat_i : idat_q;
   assign dwb_dat_o = dwb_ack_o ? wb_dat_i : ddat_q;

   assign wb_cyc_o  = stb_q;
   assign wb_stb_o  = stb_q;
   assign wb_wre_o  = wre_q;
   assign wb_sel_o  = sel_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;

endmodule

// File: doc/aemb_wbarb.md
AEMB_WBARB -- requirements
Module: aemb_wbarb

Interface
REQ-001 Parameter AW, default 32, is the address width; address ports carry bits [AW-1:2].
REQ-002 Parameter TMO, default 255, is the timeout in cycles (8-bit); 0 SHALL disable the timeout.
REQ-003 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-004 sys_clk_i  in  1  clock; all state SHALL update on its rising edge.
REQ-005 sys_rst_i  in  1  synchronous, active-high reset.
REQ-006 iwb_stb_i  in  1  instruction-port request (read-only).
REQ-007 iwb_adr_i  in  AW-2  instruction word address.
REQ-008 iwb_dat_o  out  32  instruction read data.
REQ-009 iwb_ack_o  out  1  instruction-port acknowledge.
REQ-010 iwb_err_o  out  1  instruction-port timeout pulse.
REQ-011 dwb_stb_i  in  1  data-port request.
REQ-012 dwb_wre_i  in  1  data-port write enable.
REQ-013 dwb_sel_i  in  4  data-port byte selects.
REQ-014 dwb_adr_i  in  AW-2  data word address.
REQ-015 dwb_dat_i  in  32  data write data.
REQ-016 dwb_dat_o  out  32  data read data.
REQ-017 dwb_ack_o  out  1  data-port acknowledge.
REQ-018 dwb_err_o  out  1  data-port timeout pulse.
REQ-019 wb_cyc_o and wb_stb_o  out  1 each  shared-bus cycle and strobe.
REQ-020 wb_wre_o  out  1  shared-bus write enable.
REQ-021 wb_sel_o  out  4  shared-bus byte selects.
REQ-022 wb_adr_o  out  AW-2  shared-bus address.
REQ-023 wb_dat_o  out  32  shared-bus write data.
REQ-024 wb_dat_i  in  32  shared-bus read data.
REQ-025 wb_ack_i  in  1  shared-bus acknowledge.

Function
REQ-026 The FSM SHALL have exactly three states: IDLE, GNT_I and GNT_D.
REQ-027 In IDLE with only dwb_stb_i high, the FSM SHALL go to GNT_D; with only iwb_stb_i high, it SHALL go to GNT_I.
REQ-028 In IDLE with both requests high, the FSM SHALL grant the port not served last, tracked by a one-bit lst register.
REQ-029 On entering a grant state, wb_adr_o, wb_sel_o, wb_wre_o and wb_dat_o SHALL be registered from the granted port.
- Instruction grant forces wb_sel_o=4'hF and wb_wre_o=0.
- wb_dat_o is unchanged on an instruction grant.
REQ-030 wb_cyc_o and wb_stb_o SHALL be high in the cycle after the request is sampled in IDLE (latency 1) and SHALL stay high while in a grant state.
REQ-031 In GNT_x with wb_ack_i high:
- x_ack_o SHALL be high in the same cycle (combinational);
- x_dat_o SHALL equal wb_dat_i in that cycle;
- lst SHALL record x;
- the FSM SHALL go to IDLE.
REQ-032 wb_cyc_o and wb_stb_o SHALL be low for at least one cycle between consecutive transactions.
REQ-033 If the granted port drops its stb while granted (abort), the FSM SHALL go to IDLE next cycle.
- No ack or err is issued.
- lst is unchanged.
REQ-034 A 9-bit counter SHALL clear on grant and increment each granted cycle without wb_ack_i.
REQ-035 When the counter equals TMO (TMO≠0), x_err_o SHALL pulse for exactly one cycle, the FSM SHALL go to IDLE, and lst SHALL record x.
REQ-036 If wb_ack_i and timeout occur in the same cycle, the ack SHALL win: no err, normal completion.
REQ-037 wb_ack_i received in IDLE SHALL be ignored: no port ack, no state change.
REQ-038 The ungranted port's ack and err SHALL be 0.
REQ-039 The ungranted port's dat_o SHALL hold its last value.
REQ-040 A request arriving during the other port's grant SHALL wait, with inputs held stable by its requester.

Reset
REQ-041 While sys_rst_i is high at a clock edge, the block SHALL enter IDLE, clear the counter and set lst=I, so that the first simultaneous request goes to D.
REQ-042 After reset, all outputs SHALL be 0, including wb_* outputs and both dat_o.
REQ-043 Reset during a grant SHALL abort the transaction with no ack or err and drop wb_stb_o next cycle.

Verification
REQ-044 Data write served:
- Stimulus: only dwb_stb_i=1, wre=1, sel=4'h3, adr=0x10, dat=0xDEADBEEF; wb_ack_i on the 3rd granted cycle.
- Response: wb_stb_o high 1 cycle after the request, with matching bus fields; dwb_ack_o a single pulse aligned with wb_ack_i.
REQ-045 Alternation under contention:
- Stimulus: both ports held requesting; 1-cycle ack slave.
- Response: grant order D,I,D,I; one idle cycle between transactions.
REQ-046 Instruction read:
- Stimulus: iwb_stb_i=1, adr=0x40; wb_dat_i=0x12345678 with ack.
- Response: iwb_dat_o=0x12345678 with iwb_ack_o; wb_sel_o=4'hF, wb_wre_o=0.
REQ-047 Timeout:
- Stimulus: TMO=4; slave never acks.
- Response: dwb_err_o one-cycle pulse after 4 granted cycles; FSM returns to IDLE; the pending instruction request is granted next.
REQ-048 Ack and timeout coincide:
- Stimulus: ack on the exact timeout cycle.
- Response: ack only, no err.
REQ-049 Reset mid-grant:
- Stimulus: sys_rst_i asserted during GNT_D.
- Response: wb_stb_o=0 next cycle; no ack or err; the next simultaneous request goes to D.
